// File: rtl/midi_pkg.sv
// Shared types and byte-class constants for the MIDI channel-voice message parser.
package midi_pkg;

  typedef enum logic [2:0] {
    NOTE_OFF = 3'd0,
    NOTE_ON  = 3'd1,
    POLY_AT  = 3'd2,
    CC       = 3'd3,
    PROG     = 3'd4,
    CHAN_AT  = 3'd5,
    PITCH    = 3'd6
  } msg_type_t;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2,
    SYSEX     = 2'd3
  } parser_state_t;

  localparam logic [7:0] STATUS_MIN  = 8'h80;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  // Program change and channel aftertouch carry a single data byte.
  function automatic logic [1:0] data_byte_count(input logic [3:0] status_nib);
    return (status_nib == 4'hC || status_nib == 4'hD) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational classification of one raw MIDI byte into its protocol class.
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_data,
  output logic       is_chan_status,
  output logic       is_sysex_start,
  output logic       is_sysex_end,
  output logic       is_sys_common,
  output logic       is_realtime
);

  assign is_data        = (byte_in < STATUS_MIN);
  assign is_chan_status = (byte_in >= STATUS_MIN) && (byte_in < SYSEX_START);
  assign is_sysex_start = (byte_in == SYSEX_START);
  assign is_sysex_end   = (byte_in == SYSEX_END);
  assign is_sys_common  = (byte_in > SYSEX_START) && (byte_in < SYSEX_END);
  assign is_realtime    = (byte_in >= RT_MIN);

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles channel-voice messages (with running status) from a FIFO byte stream.
// Optional MIDI_VEL0_NOTE_OFF_EN: report NOTE_ON with velocity 0 as NOTE_OFF.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter int DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output msg_type_t             msg_type,
  output logic [3:0]            msg_chan,
  output logic [6:0]            msg_data1,
  output logic [6:0]            msg_data2,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  parser_state_t state_q, state_d;
  logic          rd_pending;
  logic [3:0]    stat_hi_q;
  logic [3:0]    chan_q;
  logic [6:0]    d1_q;

  logic          is_data, is_chan_status, is_sysex_start;
  logic          is_sysex_end, is_sys_common, is_realtime;

  logic          latch_status, latch_d1, emit, count_drop;
  msg_type_t     emit_type;
  logic [6:0]    emit_d1, emit_d2;

  midi_byte_classify u_classify (
    .byte_in        (fifo_dout),
    .is_data        (is_data),
    .is_chan_status (is_chan_status),
    .is_sysex_start (is_sysex_start),
    .is_sysex_end   (is_sysex_end),
    .is_sys_common  (is_sys_common),
    .is_realtime    (is_realtime)
  );

  // A held record blocks popping so backpressure parks bytes in the FIFO.
  assign fifo_rd_en = !reset && !fifo_empty && !rd_pending && !(msg_valid && !msg_ready);

  always_ff @(posedge clk) begin
    if (reset) state_q <= NO_STATUS;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    latch_status = 1'b0;
    latch_d1     = 1'b0;
    emit         = 1'b0;
    count_drop   = 1'b0;
    emit_d1      = d1_q;
    emit_d2      = fifo_dout[6:0];
    emit_type    = msg_type_t'(stat_hi_q[2:0]);

    if (rd_pending) begin
      if (is_realtime) begin
        state_d = state_q;
      end else if (is_chan_status) begin
        latch_status = 1'b1;
        state_d      = WAIT_D1;
      end else if (is_sysex_start) begin
        state_d = SYSEX;
      end else if (is_sys_common || is_sysex_end) begin
        state_d = NO_STATUS;
      end else if (is_data) begin
        case (state_q)
          NO_STATUS: count_drop = 1'b1;
          WAIT_D1: begin
            if (data_byte_count(stat_hi_q) == 2'd1) begin
              emit    = 1'b1;
              emit_d1 = fifo_dout[6:0];
              emit_d2 = 7'd0;
            end else begin
              latch_d1 = 1'b1;
              state_d  = WAIT_D2;
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            state_d = WAIT_D1;
          end
          SYSEX:   state_d = SYSEX;
          default: state_d = NO_STATUS;
        endcase
      end
    end

`ifdef MIDI_VEL0_NOTE_OFF_EN
    if (emit_type == NOTE_ON && emit_d2 == 7'd0) emit_type = NOTE_OFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      stat_hi_q  <= '0;
      chan_q     <= '0;
      d1_q       <= '0;
      msg_valid  <= 1'b0;
      msg_type   <= NOTE_OFF;
      msg_chan   <= '0;
      msg_data1  <= '0;
      msg_data2  <= '0;
      drop_cnt   <= '0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (latch_status) begin
        stat_hi_q <= fifo_dout[7:4];
        chan_q    <= fifo_dout[3:0];
      end
      if (latch_d1) d1_q <= fifo_dout[6:0];
      if (count_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      if (emit) begin
        msg_valid <= 1'b1;
        msg_type  <= emit_type;
        msg_chan  <= chan_q;
        msg_data1 <= emit_d1;
        msg_data2 <= emit_d2;
      end else if (msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

endmodule
